udp_tx_arb: RTL and testbench
=============================

// Module: udp_tx_arb
// PURPOSE
// - Shares the MAC UDP transmit path between two payload sources (src0 = RX echo/loopback, src1 = status report).
// - Grants round-robin and drives the fs/fd start/done handshake plus udp_tx_len toward the MAC.
// - Streams payload bytes from the granted source's FWFT FIFO on each MAC byte request.
// - Sits between the source FIFOs and the MAC udp_tx* ports, in the gmii_txc domain.
// PARAMETERS
// - LEN_W    12    width of source length inputs (max payload 4095 bytes)
// - TIMEOUT  4096  watchdog cycles, used only when UDP_TX_TIMEOUT_EN is defined
// PORTS
// - clk              in   1      gmii_txc; all logic on rising edge
// - rst_n            in   1      synchronous, active-low reset
// - req0/req1        in   1      source requests a frame; held high until its doneN
// - len0/len1        in   LEN_W  payload byte count; stable while reqN high
// - rxd0/rxd1        in   8      FWFT FIFO head byte of each source
// - rden0/rden1      out  1      pop one byte from source FIFO (combinational)
// - gnt0/gnt1        out  1      source currently owns the TX path
// - done0/done1      out  1      one-cycle pulse: frame finished or aborted
// - fs_udp_tx        out  1      start level to MAC
// - fd_udp_tx        in   1      MAC frame-done
// - udp_tx_len       out  16     payload length to MAC, zero-extended lenN
// - flag_udp_tx_req  in   1      MAC byte request, one byte per high cycle
// - udp_txd          out  8      payload byte to MAC
// - busy             out  1      state != IDLE
// - err              out  1      sticky watchdog abort flag
// BEHAVIOUR
// - Reset (rst_n low at clk edge): state IDLE; all outputs 0; RR pointer favours src0. Reset mid-frame aborts immediately: no doneN pulse, FIFO contents untouched.
// - States: IDLE -> ARB -> START -> STREAM -> WAIT_FD -> DONE -> IDLE.
// - IDLE: any reqN high -> ARB.
// - ARB (1 cycle): one request -> grant it. Both -> grant the source not served last. Latch lenN, set gntN.
//   - Latched len==0: -> DONE; no fs/MAC transaction.
//   - Otherwise -> START.
// - START: fs_udp_tx=1, udp_tx_len={0,len}; -> STREAM next cycle. fs stays high through STREAM/WAIT_FD.
// - STREAM: byte counter cnt from 0.
//   - Each cycle flag_udp_tx_req=1 and cnt<len: rdenN=1 the same cycle; udp_txd<=rxdN registered; cnt++.
//   - Data is therefore valid one cycle after the request.
//   - Requests with cnt>=len: udp_txd<=8'h00, no rden (pad, no FIFO underflow).
//   - cnt==len -> WAIT_FD.
// - fd_udp_tx sampled high in STREAM or WAIT_FD: fs_udp_tx=0 next cycle; -> DONE. Early fd (cnt<len) ends the frame; no further rden.
// - DONE (1 cycle): doneN=1, gntN=0, RR pointer <= N; -> IDLE. The source must drop reqN; a reqN still high the cycle after doneN is a new request.
// - Requests arriving while busy wait; no preemption. gnt0 and gnt1 are never high together.
// - Widths: cnt is LEN_W bits, compared against the latched len; no wrap possible.
// CONFIGURATION
// - UDP_TX_TIMEOUT_EN defined:
//   - A watchdog counts cycles in START/STREAM/WAIT_FD and clears on entering START.
//   - Reaching TIMEOUT sets err=1 (sticky until reset), drops fs, and moves to DONE (doneN pulses).
// - UDP_TX_TIMEOUT_EN undefined: no watchdog logic; err tied 0; the FSM waits for fd indefinitely.
// TESTING
// - req0, len0=5, MAC requests 5 contiguous cycles -> fs high, udp_tx_len=5; rden0 x5; bytes in FIFO order; fd -> done0 once, busy=0.
// - req0 and req1 high at the same edge after reset, len=3 each -> src0 served first, then src1. Repeat -> src1 first if src0 was last.
// - len1=0 -> gnt1 high 1 cycle, done1 pulse; fs_udp_tx never asserted.
// - len0=4, MAC requests 6 bytes -> 4 rden0, last two udp_txd=8'h00; FIFO not overread.
// - rst_n low during STREAM at cnt=2 -> next cycle all outputs 0, state IDLE, no done0.
// - UDP_TX_TIMEOUT_EN with TIMEOUT=16, fd never given -> after 16 cycles err=1, fs=0, done0 pulse; err persists until reset.

Source files
------------

// File: rtl/udp_tx_arb.sv
// Round-robin arbiter sharing the MAC UDP transmit path between two FWFT payload sources.
// Optional watchdog abort is compiled in when UDP_TX_TIMEOUT_EN is defined.
module udp_tx_arb #(
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       rxd0,
  input  logic [7:0]       rxd1,
  output logic             rden0,
  output logic             rden1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             fs_udp_tx,
  input  logic             fd_udp_tx,
  output logic [15:0]      udp_tx_len,
  input  logic             flag_udp_tx_req,
  output logic [7:0]       udp_txd,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_STREAM, S_WAIT_FD, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       txd_q, txd_d;
  logic             active;
  logic             pop;
  logic             timeout;
  logic [7:0]       rxd_sel;

  assign active  = (state_q inside {S_START, S_STREAM, S_WAIT_FD});
  assign rxd_sel = sel_q ? rxd1 : rxd0;
  assign pop     = (state_q == S_STREAM) && flag_udp_tx_req && (cnt_q < len_q);

`ifdef UDP_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout = active && (wd_q == WD_W'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_ARB)
        wd_q <= '0;
      else if (active)
        wd_q <= wd_q + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // last_q resets to src1 so that a simultaneous first request goes to src0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1)
          state_d = S_ARB;
      end
      S_ARB: begin
        if (req0 && req1)
          sel_d = ~last_q;
        else
          sel_d = req1;
        len_d   = sel_d ? len1 : len0;
        cnt_d   = '0;
        state_d = (len_d == '0) ? S_DONE : S_START;
      end
      S_START: begin
        state_d = timeout ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        // requests past the latched length are answered with pad bytes
        if (flag_udp_tx_req)
          txd_d = pop ? rxd_sel : 8'h00;
        if (pop)
          cnt_d = cnt_q + 1'b1;
        if (fd_udp_tx || timeout)
          state_d = S_DONE;
        else if (cnt_q == len_q)
          state_d = S_WAIT_FD;
      end
      S_WAIT_FD: begin
        if (flag_udp_tx_req)
          txd_d = 8'h00;
        if (fd_udp_tx || timeout)
          state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fs_udp_tx  = active;
    gnt0       = (active || (state_q == S_DONE)) && !sel_q;
    gnt1       = (active || (state_q == S_DONE)) &&  sel_q;
    done0      = (state_q == S_DONE) && !sel_q;
    done1      = (state_q == S_DONE) &&  sel_q;
    rden0      = pop && !sel_q;
    rden1      = pop &&  sel_q;
    busy       = (state_q != S_IDLE);
    udp_tx_len = 16'(len_q);
    udp_txd    = txd_q;
  end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed testbench for udp_tx_arb (default build, watchdog disabled).
module tb_udp_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [11:0] len0, len1;
  logic [7:0]  rxd0, rxd1;
  logic        rden0, rden1, gnt0, gnt1, done0, done1;
  logic        fs_udp_tx, fd_udp_tx, flag_udp_tx_req;
  logic [15:0] udp_tx_len;
  logic [7:0]  udp_txd;
  logic        busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem0 [0:31];
  logic [7:0] mem1 [0:31];
  logic [7:0] cap  [0:7];
  int         rptr0 = 0, rptr1 = 0;
  logic       fifo_clr;
  int         done0_cnt = 0, done1_cnt = 0, fs_cnt = 0, both_gnt = 0;

  always #5 clk = ~clk;

  udp_tx_arb #(.LEN_W(12), .TIMEOUT(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .rxd0(rxd0), .rxd1(rxd1), .rden0(rden0), .rden1(rden1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx), .udp_tx_len(udp_tx_len),
    .flag_udp_tx_req(flag_udp_tx_req), .udp_txd(udp_txd),
    .busy(busy), .err(err)
  );

  // FWFT FIFO models and event monitors
  always @(posedge clk) begin
    if (fifo_clr) begin
      rptr0 <= 0;
      rptr1 <= 0;
    end else begin
      if (rden0) rptr0 <= rptr0 + 1;
      if (rden1) rptr1 <= rptr1 + 1;
    end
    if (done0) done0_cnt <= done0_cnt + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
    if (fs_udp_tx) fs_cnt <= fs_cnt + 1;
    if (gnt0 && gnt1) both_gnt <= both_gnt + 1;
  end

  assign rxd0 = mem0[rptr0[4:0]];
  assign rxd1 = mem1[rptr1[4:0]];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic wait_fs(output bit ok, output logic [15:0] len_seen, output bit g0, output bit g1);
    ok = 0; len_seen = '0; g0 = 0; g1 = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (fs_udp_tx) begin
        ok = 1; len_seen = udp_tx_len; g0 = gnt0; g1 = gnt1;
      end
    end
  endtask

  // Enters STREAM, issues nreq contiguous byte requests, then pulses fd; ends in the DONE cycle
  task automatic mac_stream(input int nreq);
    tick();
    for (int k = 0; k < nreq; k++) begin
      flag_udp_tx_req = 1'b1;
      tick();
      cap[k] = udp_txd;
    end
    flag_udp_tx_req = 1'b0;
    fd_udp_tx = 1'b1;
    tick();
    fd_udp_tx = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (fs_udp_tx !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", fs_udp_tx); end
    n_checks++; if ({gnt0, gnt1} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
    n_checks++; if ({done0, done1, rden0, rden1} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {done0, done1, rden0, rden1}); end
    n_checks++; if (udp_tx_len !== 16'd0) begin n_fail++; $display("FAIL reset_len: got %0d expected 0", udp_tx_len); end
    n_checks++; if (udp_txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h expected 00", udp_txd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    bit ok, g0, g1;
    logic [15:0] ls;
    int d0;
    logic [7:0] exp_b [0:4] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    clear_fifo();
    d0 = done0_cnt;
    req0 = 1'b1; len0 = 12'd5;
    wait_fs(ok, ls, g0, g1);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_fs: got no fs expected fs within 20 cycles"); end
    n_checks++; if (ls !== 16'd5) begin n_fail++; $display("FAIL single_len: got %0d expected 5", ls); end
    n_checks++; if ({g0, g1} !== 2'b10) begin n_fail++; $display("FAIL single_gnt: got %b expected 10", {g0, g1}); end
    mac_stream(5);
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (cap[k] !== exp_b[k]) begin n_fail++; $display("FAIL single_byte%0d: got %h expected %h", k, cap[k], exp_b[k]); end
    end
    n_checks++; if (done0 !== 1'b1 || fs_udp_tx !== 1'b0) begin n_fail++; $display("FAIL single_done: got done0=%b fs=%b expected done0=1 fs=0", done0, fs_udp_tx); end
    req0 = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b gnt0=%b expected 0 0", busy, gnt0); end
    tick();
    n_checks++; if (rptr0 !== 5) begin n_fail++; $display("FAIL single_pops: got %0d expected 5", rptr0); end
    n_checks++; if (done0_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done0_cnt - d0); end
  endtask

  task automatic test_round_robin();
    bit ok, g0, g1;
    logic [15:0] ls;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    clear_fifo();
    req0 = 1'b1; req1 = 1'b1; len0 = 12'd3; len1 = 12'd3;
    wait_fs(ok, ls, g0, g1);
    n_checks++; if (!ok || {g0, g1} !== 2'b10) begin n_fail++; $display("FAIL rr_first: got ok=%b gnt=%b expected ok=1 gnt=10", ok, {g0, g1}); end
    mac_stream(3);
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL rr_done0: got %b expected 1", done0); end
    req0 = 1'b0;
    wait_fs(ok, ls, g0, g1);
    n_checks++; if (!ok || {g0, g1} !== 2'b01) begin n_fail++; $display("FAIL rr_second: got ok=%b gnt=%b expected ok=1 gnt=01", ok, {g0, g1}); end
    mac_stream(3);
    n_checks++; if ({cap[0], cap[1], cap[2]} !== 24'h404142) begin n_fail++; $display("FAIL rr_src1_bytes: got %h expected 404142", {cap[0], cap[1], cap[2]}); end
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL rr_done1: got %b expected 1", done1); end
    req1 = 1'b0;
    tick();
    // src1 served last: simultaneous requests go to src0
    req0 = 1'b1; req1 = 1'b1;
    wait_fs(ok, ls, g0, g1);
    n_checks++; if (!ok || {g0, g1} !== 2'b10) begin n_fail++; $display("FAIL rr_repeat_first: got ok=%b gnt=%b expected ok=1 gnt=10", ok, {g0, g1}); end
    mac_stream(3);
    req0 = 1'b0;
    wait_fs(ok, ls, g0, g1);
    mac_stream(3);
    req1 = 1'b0;
    tick();
    // src0 alone, then both: src1 must win
    req0 = 1'b1;
    wait_fs(ok, ls, g0, g1);
    mac_stream(3);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1;
    wait_fs(ok, ls, g0, g1);
    n_checks++; if (!ok || {g0, g1} !== 2'b01) begin n_fail++; $display("FAIL rr_after_src0: got ok=%b gnt=%b expected ok=1 gnt=01", ok, {g0, g1}); end
    mac_stream(3);
    req1 = 1'b0;
    wait_fs(ok, ls, g0, g1);
    mac_stream(3);
    req0 = 1'b0;
    tick(); tick();
    n_checks++; if (both_gnt !== 0) begin n_fail++; $display("FAIL rr_gnt_exclusive: got %0d overlap cycles expected 0", both_gnt); end
  endtask

  task automatic test_zero_length();
    int f0, d1;
    bit seen, g1;
    f0 = fs_cnt; d1 = done1_cnt; seen = 0; g1 = 0;
    req1 = 1'b1; len1 = 12'd0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (done1) begin seen = 1; g1 = gnt1; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL zero_done1: got no done1 expected pulse within 10 cycles"); end
    n_checks++; if (g1 !== 1'b1) begin n_fail++; $display("FAIL zero_gnt1: got %b expected 1", g1); end
    req1 = 1'b0;
    tick();
    n_checks++; if (gnt1 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got gnt1=%b busy=%b expected 0 0", gnt1, busy); end
    tick();
    n_checks++; if (fs_cnt - f0 !== 0) begin n_fail++; $display("FAIL zero_no_fs: got %0d fs cycles expected 0", fs_cnt - f0); end
    n_checks++; if (done1_cnt - d1 !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done1_cnt - d1); end
  endtask

  task automatic test_pad();
    bit ok, g0, g1;
    logic [15:0] ls;
    logic [7:0] exp_b [0:5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h00};
    clear_fifo();
    req0 = 1'b1; len0 = 12'd4;
    wait_fs(ok, ls, g0, g1);
    n_checks++; if (!ok || ls !== 16'd4) begin n_fail++; $display("FAIL pad_start: got ok=%b len=%0d expected ok=1 len=4", ok, ls); end
    mac_stream(6);
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (cap[k] !== exp_b[k]) begin n_fail++; $display("FAIL pad_byte%0d: got %h expected %h", k, cap[k], exp_b[k]); end
    end
    req0 = 1'b0;
    tick();
    n_checks++; if (rptr0 !== 4) begin n_fail++; $display("FAIL pad_pops: got %0d expected 4", rptr0); end
  endtask

  task automatic test_reset_midframe();
    bit ok, g0, g1;
    logic [15:0] ls;
    int d0;
    clear_fifo();
    req0 = 1'b1; len0 = 12'd6;
    wait_fs(ok, ls, g0, g1);
    tick();
    flag_udp_tx_req = 1'b1;
    tick(); tick();
    flag_udp_tx_req = 1'b0;
    rst_n = 1'b0;
    d0 = done0_cnt;
    tick();
    n_checks++; if (busy !== 1'b0 || fs_udp_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got busy=%b fs=%b expected 0 0", busy, fs_udp_tx); end
    n_checks++; if ({gnt0, done0, rden0} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 000", {gnt0, done0, rden0}); end
    n_checks++; if (udp_txd !== 8'h00 || udp_tx_len !== 16'd0) begin n_fail++; $display("FAIL midrst_data: got txd=%h len=%0d expected 00 0", udp_txd, udp_tx_len); end
    rst_n = 1'b1; req0 = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (done0_cnt - d0 !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", done0_cnt - d0); end
    n_checks++; if (rptr0 !== 2) begin n_fail++; $display("FAIL midrst_pops: got %0d expected 2", rptr0); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b err=%b expected 0 0", busy, err); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 8'(16 + i);
      mem1[i] = 8'(64 + i);
    end
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    fd_udp_tx = 1'b0; flag_udp_tx_req = 1'b0; fifo_clr = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_zero_length();
    test_pad();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
